// File: rtl/n64adv2_vtiming_monitor.sv
// rtl/n64adv2_vtiming_monitor.sv - passive per-frame timing/lock monitor on the HDMI output stream
// Optional frame CRC: VTIMING_MONITOR_CRC_EN
module n64adv2_vtiming_monitor #(
    parameter int color_width = 8,
    parameter int lock_frames = 4
) (
    input  logic                       HDMI_CLK_w,
    input  logic                       HDMI_nRST_w,
    input  logic                       VSYNC_i,
    input  logic                       HSYNC_i,
    input  logic                       DE_i,
    input  logic [3*color_width-1:0]   VD_i,
    input  logic                       vsync_neg_i,
    input  logic                       hsync_neg_i,
    output logic [11:0]                htotal_o,
    output logic [11:0]                hactive_o,
    output logic [10:0]                vtotal_o,
    output logic [10:0]                vactive_o,
    output logic                       overflow_o,
    output logic                       locked_o,
    output logic                       frame_tgl_o,
    output logic [15:0]                crc_o
);
    localparam int VDW = 3*color_width;
    localparam logic [11:0] HMAX = 12'hFFF;
    localparam logic [10:0] VMAX = 11'h7FF;
    localparam logic [3:0]  LF   = 4'(lock_frames);

    logic vs_r, hs_r, de_r, vneg_r, hneg_r, vs_n_d, hs_n_d;
    logic [11:0] hcnt, hact, line_len, hact_line;
    logic [10:0] vcnt, vact;
    logic de_seen, ovf, first_frame;
    logic [3:0] match_cnt;

    wire vs_n    = vs_r ^ vneg_r;
    wire hs_n    = hs_r ^ hneg_r;
    wire vs_edge = vs_n & ~vs_n_d;
    wire hs_edge = hs_n & ~hs_n_d;

    // Values that the closing frame would publish, including a coincident hsync edge
    logic [11:0] pub_htotal, pub_hactive;
    logic [10:0] pub_vtotal, pub_vactive;
    logic ovf_now, lock_match;
    logic [3:0] mc_next;

    always_comb begin
        pub_htotal  = hs_edge ? hcnt : line_len;
        pub_hactive = (hs_edge && hact != 12'd0) ? hact : hact_line;
        pub_vtotal  = vcnt;
        pub_vactive = vact + 11'(hs_edge & de_seen);
        ovf_now     = ovf | (~hs_edge & (hcnt == HMAX)) | (hs_edge & (vcnt == VMAX));
        lock_match  = !ovf_now && pub_htotal == htotal_o && pub_hactive == hactive_o &&
                      pub_vtotal == vtotal_o && pub_vactive == vactive_o;
        mc_next     = !lock_match ? 4'd0 : ((match_cnt >= LF) ? LF : match_cnt + 4'd1);
    end

    always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
        if (!HDMI_nRST_w) begin
            {vs_r, hs_r, de_r, vneg_r, hneg_r, vs_n_d, hs_n_d} <= '0;
            hcnt <= '0; hact <= '0; line_len <= '0; hact_line <= '0;
            vcnt <= '0; vact <= '0; de_seen <= 1'b0; ovf <= 1'b0;
            first_frame <= 1'b1; match_cnt <= '0;
            htotal_o <= '0; hactive_o <= '0; vtotal_o <= '0; vactive_o <= '0;
            overflow_o <= 1'b0; locked_o <= 1'b0; frame_tgl_o <= 1'b0;
        end else begin
            vs_r   <= VSYNC_i;
            hs_r   <= HSYNC_i;
            de_r   <= DE_i;
            vneg_r <= vsync_neg_i;
            hneg_r <= hsync_neg_i;
            vs_n_d <= vs_n;
            hs_n_d <= hs_n;

            if (hs_edge) begin
                line_len <= hcnt;
                hcnt     <= 12'd1;
                if (hact != 12'd0)
                    hact_line <= hact;
                hact    <= {11'd0, de_r};
                de_seen <= de_r;
            end else begin
                if (hcnt != HMAX)
                    hcnt <= hcnt + 12'd1;
                if (de_r && hact != HMAX)
                    hact <= hact + 12'd1;
                if (de_r)
                    de_seen <= 1'b1;
            end

            if (vs_edge) begin
                vcnt <= {10'd0, hs_edge};
                vact <= '0;
                ovf  <= 1'b0;
                if (first_frame) begin
                    first_frame <= 1'b0;
                end else begin
                    htotal_o    <= pub_htotal;
                    hactive_o   <= pub_hactive;
                    vtotal_o    <= pub_vtotal;
                    vactive_o   <= pub_vactive;
                    overflow_o  <= ovf_now;
                    match_cnt   <= mc_next;
                    locked_o    <= (mc_next == LF);
                    frame_tgl_o <= ~frame_tgl_o;
                end
            end else begin
                ovf <= ovf_now;
                if (hs_edge) begin
                    if (vcnt != VMAX)
                        vcnt <= vcnt + 11'd1;
                    if (de_seen && vact != VMAX)
                        vact <= vact + 11'd1;
                end
            end
        end
    end

`ifdef VTIMING_MONITOR_CRC_EN
    logic [VDW-1:0] vd_r;
    logic [15:0] crc_acc;

    // CRC-16-CCITT, whole pixel word per clock, MSB first
    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [VDW-1:0] d);
        logic [15:0] r;
        r = c;
        for (int i = VDW-1; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    always_ff @(posedge HDMI_CLK_w or negedge HDMI_nRST_w) begin
        if (!HDMI_nRST_w) begin
            vd_r    <= '0;
            crc_acc <= 16'hFFFF;
            crc_o   <= '0;
        end else begin
            vd_r <= VD_i;
            if (vs_edge) begin
                crc_acc <= 16'hFFFF;
                if (!first_frame)
                    crc_o <= crc_acc;
            end else if (de_r) begin
                crc_acc <= crc16_step(crc_acc, vd_r);
            end
        end
    end
`else
    logic unused_vd;
    assign unused_vd = ^VD_i;
    assign crc_o = 16'h0000;
`endif
endmodule
